pcs_scrambler_mlane: RTL and testbench
======================================

Name: pcs_scrambler_mlane

Overview:
Parametrised multi-lane 64b/66b PCS self-synchronising scrambler/descrambler, polynomial 1 + X39 + X58. Each lane has its own 58-bit state, and the lane data width is configurable. A valid/ready handshake with a registered output stage gives back-pressure support. Runtime modes are scramble, descramble and bypass, with a CSR seed load and per-lane sync-header checking. Sits between the encoder and the gearbox on TX; the same block is instantiated between the block-sync and the decoder on RX.

Parameters:
NUM_LANES, 4, number of independent lanes.
WIDTH, 64, payload bits per lane per beat; legal range 1..128.
SEED_RST, 58'h3FF_FFFF_FFFF_FFFF, per-lane state value after reset (all ones).

Ports:
CLK  in  1  clock; all logic on rising edge.
RST_N  in  1  asynchronous active-low reset.
CSR_PCS_SCRAMB_DIS  in  1  1 = bypass; data passes unscrambled and state is frozen.
CSR_DESCRAMB_MODE  in  1  0 = scramble (TX), 1 = descramble (RX); ignored in bypass.
CSR_SEED_LOAD  in  1  single-cycle pulse; loads CSR_SEED into every lane state.
CSR_SEED  in  58  seed value.
DIN_VALID  in  1  input beat valid.
DIN_READY  out  1  input beat accepted when DIN_VALID && DIN_READY.
DIN  in  NUM_LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]; bit 0 sent first.
DIN_SH  in  NUM_LANES*2  lane k sync header at [2k +: 2].
DOUT_VALID  out  1  output beat valid.
DOUT_READY  in  1  downstream accept.
DOUT  out  NUM_LANES*(WIDTH+2)  lane k at [k*(WIDTH+2) +: WIDTH+2]; payload in the upper WIDTH bits, SH in the lower 2 bits.
SH_ERR  out  NUM_LANES  per-lane flag, aligned with DOUT: SH was 2'b00 or 2'b11.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - DOUT = 0, DOUT_VALID = 0, SH_ERR = 0.
  - Every lane state = SEED_RST.
  - DIN_READY = 1 while DOUT_VALID = 0.
- Handshake:
  - DIN_READY = !DOUT_VALID || DOUT_READY, a single output register with no skid.
  - Accepted beat appears on DOUT exactly 1 cycle later.
  - DOUT_VALID clears when DOUT_READY = 1 and no new beat is accepted.
  - DOUT, DOUT_VALID and SH_ERR hold stable while DOUT_VALID && !DOUT_READY.
- Scramble, per lane, bit index i = 0..WIDTH-1:
  - h[57:0] = state; h[58+i] = d[i] ^ h[58+i-39] ^ h[58+i-58]; out[i] = h[58+i].
  - next state = h[WIDTH+57:WIDTH].
- Descramble, per lane:
  - g[57:0] = state; g[58+i] = d[i]; out[i] = d[i] ^ g[58+i-39] ^ g[58+i-58].
  - next state = g[WIDTH+57:WIDTH].
- Bypass: out = d; state unchanged.
- SH passes through unmodified in every mode; it never enters the scrambler.
- State updates only on an accepted beat, never on stalled or idle cycles.
- Seed load has priority over the state update:
  - A beat accepted in the same cycle is processed with the old state.
  - State after that cycle = CSR_SEED in all lanes.
- Mode CSRs are sampled on the accept cycle. A mode change mid-stream takes effect on the next accepted beat; state is not reset.
- Reset asserted mid-stream: the pending output beat is discarded; DOUT_VALID = 0 immediately.

Optional Feature:
Macro PCS_SCRAMB_STATS_EN.
- Defined:
  - Adds ports CSR_STATS_CLR (in, 1) and SH_ERR_CNT (out, NUM_LANES*16).
  - One 16-bit counter per lane increments once per accepted beat with an invalid SH.
  - Counters saturate at 16'hFFFF and reset to 0.
  - CSR_STATS_CLR clears counters to 0. A simultaneous increment is lost (clear wins).
- Undefined: ports and counters are absent; SH_ERR is still produced.

Test Plan:
- Bypass, lane0 DIN=64'h0123_4567_89AB_CDEF, SH=2'b01, DOUT_READY=1 -> next cycle lane0 DOUT={64'h0123_4567_89AB_CDEF,2'b01}, DOUT_VALID=1, SH_ERR=0.
- Seed load 58'h0, then DIN=0 for 3 beats in scramble mode -> every DOUT payload = 0 and state stays 0. Then DIN bit0=1 on one beat -> output bit0=1, bit39 matches the model.
- Scramble 1000 random beats, feed DOUT into a second instance in descramble mode with a different seed -> outputs match the original DIN from beat 2 onward (self-sync within 58 bits).
- DOUT_READY low for 3 cycles with DIN_VALID high -> DOUT stable, DIN_READY=0, state unchanged. On release, the stream continues with no loss or duplication, checked against the model.
- Lane2 SH=2'b11 -> SH_ERR=4'b0100 on that output beat. With PCS_SCRAMB_STATS_EN, lane2 count=1. Forcing 70000 errors -> count=16'hFFFF.
- RST_N pulsed low with DOUT_VALID=1 -> DOUT_VALID=0 asynchronously. After release, the first beat is scrambled from an all-ones state.

Source files
------------

// File: rtl/pcs_scrambler_mlane.sv
// Multi-lane 64b/66b PCS self-synchronising scrambler/descrambler, polynomial 1 + x^39 + x^58.
// Optional per-lane sync-header error counters when PCS_SCRAMB_STATS_EN is defined.

module pcs_scrambler_mlane_lane #(
   parameter int WIDTH = 64
) (
   input  logic [57:0]      state_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             bypass_i,
   input  logic             descramble_i,
   output logic [WIDTH-1:0] d_o,
   output logic [57:0]      state_o
);
   // h holds the line-bit history: [57:0] is the stored state, [58+i] the bit on the wire at index i
   logic [WIDTH+57:0] h;

   always_comb begin
      h        = '0;
      h[57:0]  = state_i;
      d_o      = d_i;
      for (int i = 0; i < WIDTH; i++) begin
         if (descramble_i) begin
            h[58+i] = d_i[i];
            d_o[i]  = d_i[i] ^ h[i+19] ^ h[i];
         end else begin
            h[58+i] = d_i[i] ^ h[i+19] ^ h[i];
            d_o[i]  = h[58+i];
         end
      end
      if (bypass_i) d_o = d_i;
   end

   assign state_o = bypass_i ? state_i : h[WIDTH+57:WIDTH];
endmodule

module pcs_scrambler_mlane #(
   parameter int          NUM_LANES = 4,
   parameter int          WIDTH     = 64,
   parameter logic [57:0] SEED_RST  = 58'h3FF_FFFF_FFFF_FFFF
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            CSR_PCS_SCRAMB_DIS,
   input  logic                            CSR_DESCRAMB_MODE,
   input  logic                            CSR_SEED_LOAD,
   input  logic [57:0]                     CSR_SEED,
`ifdef PCS_SCRAMB_STATS_EN
   input  logic                            CSR_STATS_CLR,
   output logic [NUM_LANES*16-1:0]         SH_ERR_CNT,
`endif
   input  logic                            DIN_VALID,
   output logic                            DIN_READY,
   input  logic [NUM_LANES*WIDTH-1:0]      DIN,
   input  logic [NUM_LANES*2-1:0]          DIN_SH,
   output logic                            DOUT_VALID,
   input  logic                            DOUT_READY,
   output logic [NUM_LANES*(WIDTH+2)-1:0]  DOUT,
   output logic [NUM_LANES-1:0]            SH_ERR
);
   typedef struct packed {
      logic [WIDTH-1:0] pay;
      logic [1:0]       sh;
   } beat_t;

   logic [NUM_LANES-1:0][57:0]      state_q, state_d, state_nxt;
   logic [NUM_LANES-1:0][WIDTH-1:0] din_l, pay;
   logic [NUM_LANES-1:0][1:0]       sh_l;
   logic [NUM_LANES-1:0]            sh_bad;
   beat_t [NUM_LANES-1:0]           dout_q, dout_d;
   logic [NUM_LANES-1:0]            sh_err_q, sh_err_d;
   logic                            vld_q, vld_d;
   logic                            accept;

   assign din_l     = DIN;
   assign sh_l      = DIN_SH;
   assign DIN_READY = !vld_q || DOUT_READY;
   assign accept    = DIN_VALID && DIN_READY;

   genvar k;
   generate
      for (k = 0; k < NUM_LANES; k++) begin : g_lane
         pcs_scrambler_mlane_lane #(.WIDTH(WIDTH)) u_lane (
            .state_i      (state_q[k]),
            .d_i          (din_l[k]),
            .bypass_i     (CSR_PCS_SCRAMB_DIS),
            .descramble_i (CSR_DESCRAMB_MODE),
            .d_o          (pay[k]),
            .state_o      (state_nxt[k])
         );
         assign sh_bad[k] = (sh_l[k] == 2'b00) || (sh_l[k] == 2'b11);
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      vld_d    = vld_q;
      dout_d   = dout_q;
      sh_err_d = sh_err_q;
      // a same-cycle beat still uses the old state; the seed just wins the write
      if (CSR_SEED_LOAD)  state_d = {NUM_LANES{CSR_SEED}};
      else if (accept)    state_d = state_nxt;
      if (DIN_READY) begin
         vld_d = DIN_VALID;
         if (DIN_VALID) begin
            for (int l = 0; l < NUM_LANES; l++) begin
               dout_d[l].pay = pay[l];
               dout_d[l].sh  = sh_l[l];
            end
            sh_err_d = sh_bad;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= {NUM_LANES{SEED_RST}};
         vld_q    <= 1'b0;
         dout_q   <= '0;
         sh_err_q <= '0;
      end else begin
         state_q  <= state_d;
         vld_q    <= vld_d;
         dout_q   <= dout_d;
         sh_err_q <= sh_err_d;
      end
   end

   assign DOUT       = dout_q;
   assign DOUT_VALID = vld_q;
   assign SH_ERR     = sh_err_q;

`ifdef PCS_SCRAMB_STATS_EN
   logic [NUM_LANES-1:0][15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (CSR_STATS_CLR)
            cnt_d[l] = '0;
         else if (accept && sh_bad[l] && (cnt_q[l] != 16'hFFFF))
            cnt_d[l] = cnt_q[l] + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign SH_ERR_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_pcs_scrambler_mlane.sv
// Scoreboard bench for pcs_scrambler_mlane: directed beats, hand-derived expectations where tractable.
module tb_pcs_scrambler_mlane;
   localparam int NL = 4;
   localparam int W  = 64;
   localparam int DW = NL*W;
   localparam int OW = NL*(W+2);

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic            byp, desc, seed_ld;
   logic [57:0]     seed;
   logic            din_valid, din_ready, dout_valid, dout_ready;
   logic [DW-1:0]   din;
   logic [2*NL-1:0] din_sh;
   logic [OW-1:0]   dout;
   logic [NL-1:0]   sh_err;
`ifdef PCS_SCRAMB_STATS_EN
   logic            stats_clr;
   logic [NL*16-1:0] err_cnt;
`endif

   always #5 CLK = ~CLK;

   pcs_scrambler_mlane #(.NUM_LANES(NL), .WIDTH(W)) dut (
      .CLK                (CLK),
      .RST_N              (RST_N),
      .CSR_PCS_SCRAMB_DIS (byp),
      .CSR_DESCRAMB_MODE  (desc),
      .CSR_SEED_LOAD      (seed_ld),
      .CSR_SEED           (seed),
`ifdef PCS_SCRAMB_STATS_EN
      .CSR_STATS_CLR      (stats_clr),
      .SH_ERR_CNT         (err_cnt),
`endif
      .DIN_VALID          (din_valid),
      .DIN_READY          (din_ready),
      .DIN                (din),
      .DIN_SH             (din_sh),
      .DOUT_VALID         (dout_valid),
      .DOUT_READY         (dout_ready),
      .DOUT               (dout),
      .SH_ERR             (sh_err)
   );

   typedef struct {
      logic [OW-1:0] dout;
      logic [NL-1:0] err;
   } exp_t;

   exp_t        sbq[$];
   logic [57:0] mst [NL];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          sb_en = 1'b1;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Serial shift-register form: w[0] is the oldest line bit, w[57] the newest.
   function automatic void lane_step(input logic [57:0] st, input logic [W-1:0] d, input bit dsc,
                                     output logic [W-1:0] o, output logic [57:0] nst);
      logic [57:0] w;
      logic        nb;
      w = st;
      for (int i = 0; i < W; i++) begin
         nb   = d[i] ^ w[19] ^ w[0];
         o[i] = nb;
         w    = {(dsc ? d[i] : nb), w[57:1]};
      end
      nst = w;
   endfunction

   function automatic exp_t model_beat(input logic [DW-1:0] d, input logic [2*NL-1:0] s);
      exp_t        e;
      logic [W-1:0] o;
      logic [57:0] n;
      for (int k = 0; k < NL; k++) begin
         if (byp) o = d[k*W +: W];
         else begin
            lane_step(mst[k], d[k*W +: W], desc, o, n);
            mst[k] = n;
         end
         e.dout[k*(W+2) +: W+2] = {o, s[2*k +: 2]};
         e.err[k] = (s[2*k +: 2] == 2'b00) || (s[2*k +: 2] == 2'b11);
      end
      return e;
   endfunction

   function automatic logic [DW-1:0] rep_d(input logic [W-1:0] x);
      return {NL{x}};
   endfunction
   function automatic logic [2*NL-1:0] rep_sh(input logic [1:0] s);
      return {NL{s}};
   endfunction
   function automatic logic [OW-1:0] rep_o(input logic [W-1:0] p, input logic [1:0] s);
      return {NL{p, s}};
   endfunction
   function automatic logic [OW-1:0] pack_o(input logic [DW-1:0] d, input logic [2*NL-1:0] s);
      logic [OW-1:0] r;
      for (int k = 0; k < NL; k++) r[k*(W+2) +: W+2] = {d[k*W +: W], s[2*k +: 2]};
      return r;
   endfunction
   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic send(input logic [DW-1:0] d, input logic [2*NL-1:0] s, input bit ld = 1'b0,
                       input bit ovr = 1'b0, input logic [OW-1:0] xo = '0);
      exp_t e;
      int   t;
      t = 0;
      @(negedge CLK);
      din = d; din_sh = s; din_valid = 1'b1;
      #1;
      while (!din_ready && t < 50) begin
         @(negedge CLK); #1; t++;
      end
      if (!din_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: DIN_READY stayed 0 for %0d cycles, required 1", t);
      end else begin
         if (ld) seed_ld = 1'b1;
         e = model_beat(d, s);
         if (ld) for (int k = 0; k < NL; k++) mst[k] = seed;
         if (ovr) e.dout = xo;
         if (sb_en) sbq.push_back(e);
      end
      @(posedge CLK); #1;
      din_valid = 1'b0; seed_ld = 1'b0;
   endtask

   task automatic load_seed(input logic [57:0] v);
      @(negedge CLK);
      seed = v; seed_ld = 1'b1;
      @(posedge CLK); #1;
      seed_ld = 1'b0;
      for (int k = 0; k < NL; k++) mst[k] = v;
   endtask

   initial forever begin
      exp_t e;
      @(negedge CLK); #2;
      if (RST_N && sb_en && dout_valid && dout_ready) begin
         if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat: got %h expected no beat", dout);
         end else begin
            e = sbq.pop_front();
            chk("dout", dout, e.dout);
            chk("sh_err", sh_err, e.err);
         end
      end
   end

   initial begin
      logic [DW-1:0]   r, sc;
      logic [W-1:0]    o;
      logic [57:0]     n;
      logic [57:0]     txs [NL];
      int              t;
      byp = 1'b0; desc = 1'b0; seed_ld = 1'b0; seed = '0;
      din_valid = 1'b0; dout_ready = 1'b1; din = '0; din_sh = '0;
`ifdef PCS_SCRAMB_STATS_EN
      stats_clr = 1'b0;
`endif
      for (int k = 0; k < NL; k++) mst[k] = '1;
      #3;
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_dout", dout, '0);
      chk("rst_sh_err", sh_err, '0);
      chk("rst_din_ready", din_ready, 1'b1);
      @(negedge CLK); RST_N = 1'b1;

      // Bypass passes data and freezes state; next scramble starts from all ones.
      byp = 1'b1;
      send(rep_d(64'h0123_4567_89AB_CDEF), rep_sh(2'b01), 0, 1, rep_o(64'h0123_4567_89AB_CDEF, 2'b01));
      byp = 1'b0;
      send(rep_d('0), rep_sh(2'b10), 0, 1, rep_o(64'h03FF_FF80_0000_0000, 2'b10));

      // Zero seed with zero data stays zero; a single 1 echoes at bits 39 and 58.
      load_seed(58'h0);
      repeat (3) send(rep_d('0), rep_sh(2'b01), 0, 1, rep_o('0, 2'b01));
      send(rep_d(64'h1), rep_sh(2'b01), 0, 1, rep_o(64'h0400_0080_0000_0001, 2'b01));

      // Invalid sync headers.
      send(rnd(), 8'b01_11_01_01);
      chk("sh_err_lane2", sh_err, 4'b0100);
      send(rnd(), 8'b10_01_10_00);
      chk("sh_err_lane0", sh_err, 4'b0001);
`ifdef PCS_SCRAMB_STATS_EN
      chk("cnt_lane2", err_cnt[32 +: 16], 16'd1);
      chk("cnt_lane0", err_cnt[0 +: 16], 16'd1);
`endif

      // Back-pressure: beat A held for 3 cycles while B waits.
      send(rnd(), rep_sh(2'b01));
      @(negedge CLK);
      dout_ready = 1'b0;
      fork
         send(rnd(), rep_sh(2'b10));
         begin
            for (int c = 0; c < 3; c++) begin
               #2;
               chk("stall_din_ready", din_ready, 1'b0);
               chk("stall_dout_valid", dout_valid, 1'b1);
               chk("stall_dout", dout, sbq[0].dout);
               @(negedge CLK);
            end
            dout_ready = 1'b1;
         end
      join
      repeat (3) send(rnd(), rep_sh(2'b01));

      // Descrambler self-syncs to an independent transmitter after one beat.
      desc = 1'b1;
      load_seed(58'h2AA_AAAA_5555_1234);
      for (int k = 0; k < NL; k++) txs[k] = 58'h0F0_F0F0_1234_5678 + 58'(k);
      for (int b = 0; b < 12; b++) begin
         r = rnd();
         for (int k = 0; k < NL; k++) begin
            lane_step(txs[k], r[k*W +: W], 1'b0, o, n);
            txs[k] = n;
            sc[k*W +: W] = o;
         end
         if (b == 0) send(sc, rep_sh(2'b01));
         else        send(sc, rep_sh(2'b01), 0, 1, pack_o(r, rep_sh(2'b01)));
      end

      // Mode changes mid-stream keep state.
      desc = 1'b0; send(rnd(), rep_sh(2'b10));
      desc = 1'b1; send(rnd(), rep_sh(2'b01));
      byp  = 1'b1; send(rnd(), rep_sh(2'b10));
      byp  = 1'b0; send(rnd(), rep_sh(2'b01));
      desc = 1'b0; send(rnd(), rep_sh(2'b01));

      // Seed load with a beat in the same cycle: beat uses old state, then zero state.
      seed = 58'h0;
      send(rnd(), rep_sh(2'b01), 1);
      send(rep_d('0), rep_sh(2'b10), 0, 1, rep_o('0, 2'b10));

`ifdef PCS_SCRAMB_STATS_EN
      repeat (4) @(negedge CLK);
      sb_en = 1'b0;
      stats_clr = 1'b1;
      @(negedge CLK); stats_clr = 1'b0;
      chk("cnt_clr", err_cnt, '0);
      din = '0; din_sh = 8'b01_11_01_01; din_valid = 1'b1;
      repeat (70000) @(negedge CLK);
      din_valid = 1'b0;
      chk("cnt_sat_lane2", err_cnt[32 +: 16], 16'hFFFF);
      chk("cnt_sat_lane1", err_cnt[16 +: 16], 16'h0);
      stats_clr = 1'b1; din_valid = 1'b1;
      @(negedge CLK); stats_clr = 1'b0; din_valid = 1'b0;
      chk("cnt_clr_wins", err_cnt[32 +: 16], 16'h0);
      @(negedge CLK);
      sb_en = 1'b1;
`endif

      // Async reset with a pending beat; first beat afterwards starts from all ones.
      repeat (3) @(negedge CLK);
      dout_ready = 1'b0;
      send(rep_d(64'hDEAD_BEEF), rep_sh(2'b01));
      chk("pend_valid", dout_valid, 1'b1);
      @(negedge CLK); #2;
      RST_N = 1'b0; #1;
      chk("async_rst_valid", dout_valid, 1'b0);
      chk("async_rst_dout", dout, '0);
      sbq.delete();
      for (int k = 0; k < NL; k++) mst[k] = '1;
      @(negedge CLK);
      RST_N = 1'b1; dout_ready = 1'b1;
`ifdef PCS_SCRAMB_STATS_EN
      chk("cnt_after_rst", err_cnt, '0);
`endif
      send(rep_d('0), rep_sh(2'b01), 0, 1, rep_o(64'h03FF_FF80_0000_0000, 2'b01));

      t = 0;
      while (sbq.size() != 0 && t < 100) begin
         @(negedge CLK); t++;
      end
      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d beats outstanding, required 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
